// File: rtl/mac_pkg.sv
// mac_pkg: shared FSM states, beat-mode encodings and default result timeout for mac_drv
package mac_pkg;
  typedef enum logic [1:0] {IDLE, WGT, DAT, RES} state_t;
  localparam logic MODE_WGT = 1'b1;
  localparam logic MODE_DAT = 1'b0;
  localparam int TO_CYC_DEF = 64;
endpackage

// File: rtl/mac_drv_fsm.sv
// mac_drv_fsm: frame sequencer with beat/result counter; RES timeout built only with MAC_DRV_TIMEOUT_EN
module mac_drv_fsm import mac_pkg::*; #(
  parameter int N = 2,
  parameter int TO_CYC = TO_CYC_DEF,
  localparam int NN = N * N,
  localparam int CW = $clog2(NN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_wgt_en,
  input  logic          i_result_v,
  output state_t        o_state,
  output logic [CW-1:0] o_cnt,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_res_we
);
  state_t r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic r_done, w_done;
  logic w_fin, w_to;
  assign w_fin = r_state == RES && i_result_v && r_cnt == CW'(N - 1);
`ifdef MAC_DRV_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] r_to;
  logic r_err;
  assign w_to = r_state == RES && !w_fin && r_to == TW'(TO_CYC - 1);
  // cycles spent in RES; err stays set until the next accepted start
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_to  <= '0;
      r_err <= 1'b0;
    end else begin
      r_to  <= r_state == RES ? r_to + 1'b1 : '0;
      r_err <= (r_state == IDLE && i_start) ? 1'b0 : r_err | w_to;
    end
  assign o_err = r_err;
`else
  assign w_to  = 1'b0;
  assign o_err = 1'b0;
`endif
  // next state, counter and completion pulse; every exit leaves the counter at 0
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_done  = 1'b0;
    case (r_state)
      IDLE: w_state = i_start ? (i_wgt_en ? WGT : DAT) : IDLE;
      WGT: begin
        w_cnt   = r_cnt == CW'(NN - 1) ? '0 : r_cnt + 1'b1;
        w_state = r_cnt == CW'(NN - 1) ? DAT : WGT;
      end
      DAT: begin
        w_cnt   = r_cnt == CW'(N - 1) ? '0 : r_cnt + 1'b1;
        w_state = r_cnt == CW'(N - 1) ? RES : DAT;
      end
      RES: begin
        w_cnt   = (w_fin || w_to) ? '0 : r_cnt + CW'(i_result_v);
        w_state = (w_fin || w_to) ? IDLE : RES;
        w_done  = w_fin;
      end
      default: w_state = IDLE;
    endcase
  end
  // state, counter and registered done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_done  <= w_done;
    end
  assign o_state  = r_state;
  assign o_cnt    = r_cnt;
  assign o_busy   = r_state != IDLE;
  assign o_done   = r_done;
  assign o_res_we = r_state == RES && i_result_v;
endmodule

// File: rtl/mac_drv.sv
// mac_drv: stages weights/data, streams them to a MAC array and captures results; MAC_DRV_TIMEOUT_EN adds a RES timeout
module mac_drv import mac_pkg::*; #(
  parameter int W = 8,
  parameter int N = 2,
  parameter int TO_CYC = TO_CYC_DEF,
  localparam int NN = N * N,
  localparam int AW = $clog2(NN + N),
  localparam int RW = $clog2(N),
  localparam int CW = $clog2(NN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_wr_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [W-1:0]  cfg_data_i,
  input  logic          start_i,
  input  logic          wgt_en_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          data_v_o,
  output logic          data_mode_o,
  output logic          data_rst_addr_o,
  output logic [W-1:0]  data_o,
  input  logic          result_v_i,
  input  logic [W-1:0]  result_i,
  input  logic [RW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_data_o
);
  logic [W-1:0] r_wgt [NN];
  logic [W-1:0] r_dat [N];
  logic [W-1:0] r_res [N];
  state_t w_state;
  logic [CW-1:0] w_cnt;
  logic w_busy, w_res_we, w_beat;
  logic [W-1:0] w_wgt, w_dat;
  mac_drv_fsm #(.N(N), .TO_CYC(TO_CYC)) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .i_start    (start_i),
    .i_wgt_en   (wgt_en_i),
    .i_result_v (result_v_i),
    .o_state    (w_state),
    .o_cnt      (w_cnt),
    .o_busy     (w_busy),
    .o_done     (done_o),
    .o_err      (err_o),
    .o_res_we   (w_res_we)
  );
  assign busy_o = w_busy;
  // staging registers survive reset so a new run can reuse the previous setup
  always_ff @(posedge clk) begin
    for (int k = 0; k < NN; k++)
      if (cfg_wr_i && !w_busy && cfg_addr_i == AW'(k)) r_wgt[k] <= cfg_data_i;
    for (int k = 0; k < N; k++)
      if (cfg_wr_i && !w_busy && cfg_addr_i == AW'(NN + k)) r_dat[k] <= cfg_data_i;
  end
  // result capture indexed by the running result count
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < N; k++) r_res[k] <= '0;
    else for (int k = 0; k < N; k++) if (w_res_we && w_cnt == CW'(k)) r_res[k] <= result_i;
  // staged word for the current beat
  always_comb begin
    w_wgt = '0;
    w_dat = '0;
    for (int k = 0; k < NN; k++) if (w_cnt == CW'(k)) w_wgt = r_wgt[k];
    for (int k = 0; k < N; k++) if (w_cnt == CW'(k)) w_dat = r_dat[k];
  end
  // readback mux, zero for unmapped addresses
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < N; k++) if (rd_addr_i == RW'(k)) rd_data_o = r_res[k];
  end
  assign w_beat          = w_state == WGT || w_state == DAT;
  assign data_v_o        = w_beat;
  assign data_mode_o     = w_state == WGT ? MODE_WGT : MODE_DAT;
  assign data_rst_addr_o = w_beat && w_cnt == '0;
  assign data_o          = w_state == WGT ? w_wgt : w_state == DAT ? w_dat : '0;
endmodule

// File: doc/mac_drv.md
MAC_DRV -- requirements
Module: mac_drv

Interface
REQ-001 SHALL have parameter W, default 8, meaning data, weight and result width.
REQ-002 SHALL have parameter N, default 2, meaning systolic matrix dimension; NN = N*N.
REQ-003 SHALL have parameter TO_CYC, default 64, meaning result timeout in cycles.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port cfg_wr_i, input, 1 bit: staging-register write strobe.
REQ-008 SHALL have port cfg_addr_i, input, $clog2(NN+N) bits: 0..NN-1 select weight y*N+x; NN..NN+N-1 select data row.
REQ-009 SHALL have port cfg_data_i, input, W bits: staging write data.
REQ-010 SHALL have port start_i, input, 1 bit: single-cycle start pulse.
REQ-011 SHALL have port wgt_en_i, input, 1 bit, sampled at start: send the weight frame before the data frame.
REQ-012 SHALL have port busy_o, output, 1 bit: high while not IDLE.
REQ-013 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port err_o, output, 1 bit: sticky timeout flag.
REQ-015 SHALL have ports data_v_o, data_mode_o, data_rst_addr_o (output, 1 bit each) and data_o (output, W bits): beat stream toward the MAC array.
REQ-016 SHALL have ports result_v_i (input, 1 bit) and result_i (input, W bits): result stream from the MAC array.
REQ-017 SHALL have ports rd_addr_i (input, $clog2(N) bits) and rd_data_o (output, W bits): captured-result readback.

Function
REQ-018 SHALL implement states IDLE, WGT, DAT and RES.
REQ-019 SHALL, in IDLE, leave IDLE on start_i: to WGT if wgt_en_i=1, otherwise to DAT; the first beat SHALL appear the cycle after start_i.
REQ-020 SHALL, in WGT, emit NN consecutive beats (data_v_o=1, data_mode_o=1, data_o=weight[k] for k=0..NN-1), then go to DAT.
REQ-021 SHALL, in DAT, emit N consecutive beats (data_v_o=1, data_mode_o=0, data_o=data[k]), then go to RES.
REQ-022 SHALL assert data_rst_addr_o only on the first beat of each frame.
REQ-023 SHALL drive data_v_o, data_mode_o, data_rst_addr_o and data_o to 0 when not in WGT or DAT.
REQ-024 SHALL, in RES, store the k-th result_v_i beat into result[k] for k=0..N-1; after the N-th beat, pulse done_o for 1 cycle and return to IDLE.
REQ-025 SHALL ignore result_v_i outside RES; beats beyond N never occur in RES, because the block exits on the N-th beat.
REQ-026 SHALL ignore start_i while busy_o=1.
REQ-027 SHALL ignore cfg_wr_i while busy_o=1 and SHALL ignore out-of-range cfg_addr_i.
REQ-028 SHALL make rd_data_o = result[rd_addr_i] combinationally; out-of-range rd_addr_i returns 0.
REQ-029 SHALL clear err_o only on reset or on the next accepted start_i.

Reset
REQ-030 SHALL, on rst, asynchronously force state IDLE and all counters to 0, and drive busy_o, done_o, err_o and all data_* outputs to 0.
REQ-031 SHALL, on rst, clear the result registers to 0; staging registers SHALL hold their contents (no reset).
REQ-032 SHALL, if rst is asserted mid-frame, abort the frame with no further beats; the first cycle after release is IDLE.

Configuration
REQ-033 SHALL, with MAC_DRV_TIMEOUT_EN defined, count cycles in RES; if TO_CYC cycles elapse without the N-th result, it SHALL set err_o, return to IDLE without done_o, and keep results received so far.
REQ-034 SHALL, without MAC_DRV_TIMEOUT_EN, wait in RES indefinitely, with err_o tied to 0.

Structure
REQ-035 SHALL take the state enum, the data_mode encodings (MODE_WGT=1, MODE_DAT=0) and the default TO_CYC from the shared package mac_pkg.
REQ-036 SHALL isolate the FSM and beat/result/timeout counters in one sub-module, mac_drv_fsm; staging, result and readback registers SHALL stay in mac_drv.

Verification (N=2, W=8)
REQ-037 SHALL cover full run: stage weights 1,2,3,4 and data 5,6; pulse start with wgt_en=1 -> beats (mode,data,rst_addr) = (1,1,1),(1,2,0),(1,3,0),(1,4,0),(0,5,1),(0,6,0) on cycles t+1..t+6; then busy_o=1 with data_v_o=0.
REQ-038 SHALL cover results: in RES, drive results 0x11 then 0x22 -> done_o pulses the cycle after 0x22; rd_addr 0 returns 0x11 and rd_addr 1 returns 0x22; busy_o=0.
REQ-039 SHALL cover data-only: start with wgt_en=0 -> exactly 2 beats (0,5,1),(0,6,0).
REQ-040 SHALL cover timeout (MAC_DRV_TIMEOUT_EN): after DAT, drive no results -> err_o=1 and IDLE after 64 cycles, no done_o; next start clears err_o.
REQ-041 SHALL cover ignored inputs: start_i and cfg_wr_i (addr 0, value 0xFF) during WGT -> no restart; a later run still emits weight 1.
REQ-042 SHALL cover reset mid-frame: assert rst after the 2nd weight beat -> all outputs 0 immediately; staged values are intact on the next run.
